// File: rtl/hotkey_ctrl_pkg.sv
// Shared types for the hotkey controller: SysCfg bundle, pad bit map,
// hotkey FSM state and request selector.
package hotkey_ctrl_pkg;

    localparam int PAD_I      = 0;
    localparam int PAD_II     = 1;
    localparam int PAD_SELECT = 2;
    localparam int PAD_RUN    = 3;
    localparam int PAD_UP     = 4;
    localparam int PAD_RIGHT  = 5;
    localparam int PAD_DOWN   = 6;
    localparam int PAD_LEFT   = 7;

    typedef struct packed {
        logic [7:0] key_save;
        logic [7:0] key_load;
        logic [7:0] key_menu;
    } SysCfg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FIRE,
        WAIT_REL
    } HkState;

    typedef enum logic [1:0] {
        HK_MENU,
        HK_SAVE,
        HK_LOAD
    } HkSel;

endpackage

// File: rtl/hotkey_ctrl_joy_sniff.sv
// Joypad port sniffer: rebuilds pad 0 from the SEL/CLR nibble reads and
// forces the pad to idle when scans stop arriving.
module hotkey_ctrl_joy_sniff #(
    parameter int TIMEOUT_CLK = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       joy_rd,
    input  logic       joy_sel,
    input  logic       joy_clr,
    input  logic [3:0] joy_dat,
    output logic [7:0] pad_state,
    output logic       pad_vld
);

    localparam int TW = $clog2(TIMEOUT_CLK + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLK);

    logic [3:0]    dir;
    logic [3:0]    btn;
    logic          dir_got;
    logic          btn_got;
    logic          done;
    logic [TW-1:0] tcnt;

    logic rd_ok;
    logic rd_dir;
    logic rd_btn;
    logic commit;

    // done blocks pads 2-5 of a multitap until the next clr
    assign rd_ok  = joy_rd & ~joy_clr & ~done;
    assign rd_dir = rd_ok & joy_sel & ~dir_got;
    assign rd_btn = rd_ok & ~joy_sel & ~btn_got;
    assign commit = (rd_dir & btn_got) | (rd_btn & dir_got);

    always_ff @(posedge clk) begin
        if (rst) begin
            dir       <= 4'h0;
            btn       <= 4'h0;
            dir_got   <= 1'b0;
            btn_got   <= 1'b0;
            done      <= 1'b0;
            tcnt      <= '0;
            pad_state <= 8'h00;
            pad_vld   <= 1'b0;
        end else begin
            pad_vld <= 1'b0;
            if (joy_clr) begin
                dir_got <= 1'b0;
                btn_got <= 1'b0;
                done    <= 1'b0;
            end else if (commit) begin
                dir_got <= 1'b0;
                btn_got <= 1'b0;
                done    <= 1'b1;
            end else begin
                if (rd_dir) begin
                    dir     <= ~joy_dat;
                    dir_got <= 1'b1;
                end
                if (rd_btn) begin
                    btn     <= ~joy_dat;
                    btn_got <= 1'b1;
                end
            end

            if (commit) begin
                pad_state <= {rd_dir ? ~joy_dat : dir,
                              rd_btn ? ~joy_dat : btn};
                pad_vld   <= 1'b1;
                tcnt      <= '0;
            end else if (tcnt != TMAX) begin
                tcnt <= tcnt + TW'(1);
                if (tcnt == TMAX - TW'(1)) begin
                    pad_state <= 8'h00;
                    pad_vld   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hotkey_ctrl.sv
// Hotkey controller: matches the sniffed pad against the configured combos
// and issues one save/load/menu request per held-and-released press.
module hotkey_ctrl
    import hotkey_ctrl_pkg::*;
#(
    parameter int HOLD_FRAMES = 3,
    parameter int TIMEOUT_CLK = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  SysCfg      cfg,
    input  logic       joy_rd,
    input  logic       joy_sel,
    input  logic       joy_clr,
    input  logic [3:0] joy_dat,
    output logic [7:0] pad_state,
    output logic       pad_vld,
    output logic       req_save,
    output logic       req_load,
    output logic       req_menu
);

    localparam logic [3:0] HOLD_N = 4'(HOLD_FRAMES);

    HkState     state;
    HkState     state_nx;
    HkSel       sel;
    HkSel       sel_nx;
    HkSel       hit_sel;
    logic [3:0] hold_cnt;
    logic [3:0] cnt_nx;
    logic       hit_menu;
    logic       hit_save;
    logic       hit_load;
    logic       any_hit;

    hotkey_ctrl_joy_sniff #(
        .TIMEOUT_CLK(TIMEOUT_CLK)
    ) u_sniff (
        .clk      (clk),
        .rst      (rst),
        .joy_rd   (joy_rd),
        .joy_sel  (joy_sel),
        .joy_clr  (joy_clr),
        .joy_dat  (joy_dat),
        .pad_state(pad_state),
        .pad_vld  (pad_vld)
    );

    assign hit_menu = (cfg.key_menu != 8'h00) && (pad_state == cfg.key_menu);
    assign hit_save = (cfg.key_save != 8'h00) && (pad_state == cfg.key_save);
    assign hit_load = (cfg.key_load != 8'h00) && (pad_state == cfg.key_load);
    assign any_hit  = hit_menu | hit_save | hit_load;

    always_comb begin
        hit_sel = HK_LOAD;
        if (hit_menu)      hit_sel = HK_MENU;
        else if (hit_save) hit_sel = HK_SAVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= HK_MENU;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            sel      <= sel_nx;
            hold_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = hold_cnt;
        req_menu = 1'b0;
        req_save = 1'b0;
        req_load = 1'b0;
        case (state)
            IDLE: begin
                if (pad_vld && any_hit) begin
                    sel_nx   = hit_sel;
                    cnt_nx   = 4'd1;
                    state_nx = (HOLD_FRAMES == 1) ? FIRE : HOLD;
                end
            end
            HOLD: begin
                if (pad_vld) begin
                    if (any_hit && hit_sel == sel) begin
                        cnt_nx = hold_cnt + 4'd1;
                        if (cnt_nx == HOLD_N) state_nx = FIRE;
                    end else if (any_hit) begin
                        sel_nx = hit_sel;
                        cnt_nx = 4'd1;
                    end else begin
                        cnt_nx   = 4'd0;
                        state_nx = IDLE;
                    end
                end
            end
            FIRE: begin
                state_nx = WAIT_REL;
                case (sel)
                    HK_MENU: req_menu = 1'b1;
                    HK_SAVE: req_save = 1'b1;
                    HK_LOAD: req_load = 1'b1;
                    default: ;
                endcase
            end
            WAIT_REL: begin
                // a timeout also commits pad_state == 0, so it releases too
                if (pad_vld && pad_state == 8'h00) begin
                    cnt_nx   = 4'd0;
                    state_nx = IDLE;
                end
            end
            default: begin
                cnt_nx   = 4'd0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: doc/hotkey_ctrl.md
Name: hotkey_ctrl

Overview:
- Sits directly downstream of sys_cfg: consumes the SysCfg key combos (key_save, key_load, key_menu) and sniffs the console joypad port.
- Reconstructs the first pad's 8-button state from the SEL/CLR nibble protocol.
- Requires each configured combo to be held for a number of scan frames.
- Emits one-cycle save/load/menu request pulses to the in-game menu / save-state logic.

Parameters:
- HOLD_FRAMES, 3, consecutive matching scan frames required before a request fires (1..15).
- TIMEOUT_CLK, 4000000, clk cycles without a completed scan before pad state is forced to 0.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cfg  in  SysCfg  config from sys_cfg; uses key_save, key_load, key_menu (8 bit each)
- joy_rd  in  1  one-cycle strobe: console read of joypad port, joy_dat stable
- joy_sel  in  1  current SEL line level
- joy_clr  in  1  current CLR line level
- joy_dat  in  4  joypad nibble, active-low
- pad_state  out  8  {Left,Down,Right,Up,Run,Select,II,I}, active-high
- pad_vld  out  1  one-cycle pulse when pad_state updated
- req_save  out  1  one-cycle request pulse
- req_load  out  1  one-cycle request pulse
- req_menu  out  1  one-cycle request pulse

Behaviour:
- Reset values:
  - all outputs 0, FSM IDLE, hold_cnt 0, timeout counter 0.
  - dir_got/btn_got 0.
- Scan capture:
  - joy_clr=1 on any cycle clears dir_got and btn_got (new scan/multitap restart).
  - joy_rd & !joy_clr & joy_sel & !dir_got: latch ~joy_dat into dir[3:0], set dir_got.
  - joy_rd & !joy_clr & !joy_sel & !btn_got: latch ~joy_dat into btn[3:0], set btn_got.
  - Further reads until the next clr are ignored (pads 2-5 of a multitap).
- Commit:
  - In the cycle after the read that makes both dir_got and btn_got 1, pad_state <= {dir,btn} and pad_vld=1 for one cycle.
  - Both flags then clear.
  - Only one commit happens per clr window.
- Timeout:
  - Counter is reset on every commit and saturates at TIMEOUT_CLK.
  - On reaching TIMEOUT_CLK: pad_state <= 0 with pad_vld pulse, once; the next commit restarts counting.
- Match (combinational on pad_state):
  - hit_k = (key_k != 0) & (pad_state == key_k); the match is exact, so a superset does not match.
  - Priority when several hit: menu > save > load. sel = highest-priority hit.
- FSM, evaluated only on pad_vld cycles unless noted:
  - IDLE:
    - if any hit: latch sel, hold_cnt=1, go to HOLD.
    - if HOLD_FRAMES==1, go straight to FIRE instead.
  - HOLD:
    - same sel still hit: hold_cnt+1; on reaching HOLD_FRAMES, go to FIRE.
    - a different hit: restart HOLD with the new sel, hold_cnt=1.
    - no hit: go to IDLE.
  - FIRE:
    - lasts exactly one cycle regardless of pad_vld; asserts req_<sel>=1.
    - then goes to WAIT_REL.
  - WAIT_REL: stays until a pad_vld with pad_state==0 (timeout also qualifies), then goes to IDLE. No retrigger while held.
- Latency: req pulse is asserted the cycle after the pad_vld that brings hold_cnt to HOLD_FRAMES.
- cfg change mid-HOLD: the match is re-evaluated at the next pad_vld with the new key; a mismatch returns to IDLE.
- Never more than one req_* high in a cycle.
- rst mid-operation: everything returns to reset values immediately; a partially captured scan is discarded.
- hold_cnt is 4 bit; no wrap, because FIRE is entered at equality.

Decomposition:
- Shared package additions:
  - PAD_* bit index constants (PAD_I=0 ... PAD_LEFT=7).
  - HkState enum {IDLE, HOLD, FIRE, WAIT_REL}.
  - HkSel enum {HK_MENU, HK_SAVE, HK_LOAD}.
- One natural sub-module: joy_sniff. It contains the capture/commit/timeout logic and outputs pad_state and pad_vld. The top holds the match logic and the FSM.

Test Plan:
- Basic combo:
  - key_menu=8'h0C, HOLD_FRAMES=3.
  - Three scans with dir nibble 4'hF and btn nibble 4'h3 (Run+Select pressed).
  - Expect req_menu one cycle after the 3rd pad_vld, exactly one pulse, pad_state=8'h0C.
- Release required:
  - Continue the same scans for 10 frames: no further req.
  - One scan with all nibbles 4'hF, then 3 more Run+Select scans: a second req_menu.
- Superset and priority:
  - key_save=8'h0C, key_menu=8'h0C: the combo yields req_menu only.
  - Pad 8'h1C with key_load=8'h0C: no req (exact match).
- Multitap and clr:
  - After clr, 10 reads alternating sel, with pad0=Run and other pads=I.
  - Expect pad_state=8'h08 and a single pad_vld.
  - clr pulsed between the dir and btn reads: no commit.
- Timeout:
  - Use TIMEOUT_CLK=100 and hold a combo for 1 frame.
  - Stop reads: pad_state goes to 0 with a pad_vld 100 cycles after the last commit; FSM goes to IDLE; no req.
- Reset and cfg change:
  - rst during HOLD (hold_cnt=2): all outputs 0 and no req afterwards.
  - key changed to 8'h01 mid-HOLD: returns to IDLE at the next pad_vld.
